// File: rtl/enigma_ctrl_if.sv
// Bundle of the Enigma controller's command, key, rotor-unit and cipher-out
// signals. The controller takes the slave view; its environment (host plus
// rotor/reflector unit) takes the master view.
interface enigma_ctrl_if;
    // Configuration and key commands
    logic        cfg_clear;
    logic        pair_wr;
    logic [25:0] pair_a;
    logic [25:0] pair_b;
    logic        pos_load;
    logic [14:0] pos_init;
    logic [2:0]  wheel_config;
    logic        cfg_err;
    logic [3:0]  pair_count;
    // Plaintext handshake
    logic        key_valid;
    logic [25:0] key_in;
    logic        key_ready;
    // Rotor/reflector unit handshake
    logic        rr_valid;
    logic [25:0] rr_in;
    logic [14:0] rr_pos;
    logic [2:0]  rr_wheel;
    logic        rr_done;
    logic [25:0] rr_out;
    // Ciphertext and status
    logic        out_valid;
    logic [25:0] out_letter;
    logic        busy;

    modport slave (
        input  cfg_clear, pair_wr, pair_a, pair_b, pos_load, pos_init, wheel_config,
        input  key_valid, key_in, rr_done, rr_out,
        output cfg_err, pair_count, key_ready, rr_valid, rr_in, rr_pos, rr_wheel,
        output out_valid, out_letter, busy
    );

    modport master (
        output cfg_clear, pair_wr, pair_a, pair_b, pos_load, pos_init, wheel_config,
        output key_valid, key_in, rr_done, rr_out,
        input  cfg_err, pair_count, key_ready, rr_valid, rr_in, rr_pos, rr_wheel,
        input  out_valid, out_letter, busy
    );
endinterface

// File: rtl/enigma_ctrl.sv
// Enigma sequencing controller: holds the plugboard table and rotor positions,
// steps the rotors (with middle-rotor double-step) before each letter, and
// runs plugboard -> rotor unit -> plugboard for one one-hot letter at a time.
module enigma_ctrl #(
    parameter int NOTCH0    = 16,
    parameter int NOTCH1    = 4,
    parameter int MAX_PAIRS = 10
) (
    input logic         clock,
    input logic         resetn,
    enigma_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [3:0] FULL_CNT = 4'(MAX_PAIRS);
    localparam logic [4:0] NOTCH_R  = 5'(NOTCH0);
    localparam logic [4:0] NOTCH_M  = 5'(NOTCH1);

    logic [1:0]  r_state;
    logic [25:0] r_slot_a [MAX_PAIRS];
    logic [25:0] r_slot_b [MAX_PAIRS];
    logic [3:0]  r_pair_cnt;
    logic [4:0]  r_pos_l, r_pos_m, r_pos_r;
    logic [2:0]  r_wheel;
    logic [25:0] r_key;
    logic [25:0] r_rr_in;
    logic [25:0] r_out_letter;
    logic        r_cfg_err;
    logic        r_ready_en;

    logic        w_idle;
    logic        w_cfg_cmd;
    logic        w_key_acc;
    logic        w_pair_ok;
    logic        w_pos_ok;
    logic        w_mid_step;
    logic        w_left_step;
    logic [25:0] w_used;
    logic [25:0] w_key_plug;
    logic [25:0] w_res_plug;

    function automatic logic is_onehot(input logic [25:0] x);
        return (x != 26'd0) && ((x & (x - 26'd1)) == 26'd0);
    endfunction

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_cfg_cmd   = bus.cfg_clear | bus.pos_load | bus.pair_wr;
    assign w_key_acc   = bus.key_valid & bus.key_ready;
    assign w_mid_step  = (r_pos_r == NOTCH_R) | (r_pos_m == NOTCH_M);
    assign w_left_step = (r_pos_m == NOTCH_M);

    assign w_pos_ok = (bus.pos_init[14:10] <= 5'd25) && (bus.pos_init[9:5] <= 5'd25) &&
                      (bus.pos_init[4:0] <= 5'd25);

    assign w_pair_ok = (r_pair_cnt != FULL_CNT) && is_onehot(bus.pair_a) &&
                       is_onehot(bus.pair_b) && (bus.pair_a != bus.pair_b) &&
                       ((w_used & (bus.pair_a | bus.pair_b)) == 26'd0);

    // Plugboard lookup for the latched key and the rotor result, plus the letters already in use
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_used     = '0;
        w_key_plug = r_key;
        w_res_plug = bus.rr_out;
        for (int i = 0; i < MAX_PAIRS; i++) begin
            if (4'(i) < r_pair_cnt) begin
                w_used = w_used | r_slot_a[i] | r_slot_b[i];
                if (r_key == r_slot_a[i])           w_key_plug = r_slot_b[i];
                else if (r_key == r_slot_b[i])      w_key_plug = r_slot_a[i];
                if (bus.rr_out == r_slot_a[i])      w_res_plug = r_slot_b[i];
                else if (bus.rr_out == r_slot_b[i]) w_res_plug = r_slot_a[i];
            end
        end
    end

    // Configuration commands, error pulse and rotor stepping
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the pair table is reset explicitly because reset must leave it empty and known.
            for (int i = 0; i < MAX_PAIRS; i++) begin
                r_slot_a[i] <= '0;
                r_slot_b[i] <= '0;
            end
            r_pair_cnt <= '0;
            r_pos_l    <= '0;
            r_pos_m    <= '0;
            r_pos_r    <= '0;
            r_wheel    <= '0;
            r_cfg_err  <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_ready_en <= 1'b1;
            r_cfg_err  <= 1'b0;
            if (!w_idle) begin
                if (w_cfg_cmd) r_cfg_err <= 1'b1;
            end else if (bus.cfg_clear) begin
                r_pair_cnt <= '0;
            end else if (bus.pos_load) begin
                if (w_pos_ok) begin
                    r_pos_l <= bus.pos_init[14:10];
                    r_pos_m <= bus.pos_init[9:5];
                    r_pos_r <= bus.pos_init[4:0];
                    r_wheel <= bus.wheel_config;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (bus.pair_wr) begin
                if (w_pair_ok) begin
                    for (int i = 0; i < MAX_PAIRS; i++) begin
                        if (4'(i) == r_pair_cnt) begin
                            r_slot_a[i] <= bus.pair_a;
                            r_slot_b[i] <= bus.pair_b;
                        end
                    end
                    r_pair_cnt <= r_pair_cnt + 4'd1;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (w_key_acc && !is_onehot(bus.key_in)) begin
                r_cfg_err <= 1'b1;
            end

            if (r_state == S_STEP) begin
                r_pos_r <= wrap_inc(r_pos_r);
                if (w_mid_step)  r_pos_m <= wrap_inc(r_pos_m);
                if (w_left_step) r_pos_l <= wrap_inc(r_pos_l);
            end
        end
    end

    // Letter sequencing: accept, step, rotor-unit request, ciphertext output
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_rr_in      <= '0;
            r_out_letter <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_key_acc && is_onehot(bus.key_in)) begin
                        r_key   <= bus.key_in;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_rr_in <= w_key_plug;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.rr_done) begin
                        r_out_letter <= w_res_plug;
                        r_state      <= S_OUT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_ready  = w_idle & r_ready_en & ~w_cfg_cmd;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.pair_count = r_pair_cnt;
    assign bus.rr_valid   = (r_state == S_ISSUE);
    assign bus.rr_in      = r_rr_in;
    assign bus.rr_pos     = {r_pos_l, r_pos_m, r_pos_r};
    assign bus.rr_wheel   = r_wheel;
    assign bus.out_valid  = (r_state == S_OUT);
    assign bus.out_letter = r_out_letter;
    assign bus.busy       = ~w_idle;
endmodule

// File: tb/tb_enigma_ctrl.sv
// Testbench for enigma_ctrl: a reference model (letter-index plug map and
// modulo-26 rotor counters) predicts each rotor request and ciphertext; a
// rotor-unit responder and an output monitor compare against queued
// expectations independently of the stimulus.
module tb_enigma_ctrl;
    localparam int N0 = 16;
    localparam int N1 = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    enigma_ctrl_if bus ();

    enigma_ctrl #(.NOTCH0(N0), .NOTCH1(N1), .MAX_PAIRS(10)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        logic [25:0] rin;
        logic [14:0] pos;
        logic [2:0]  wheel;
        logic [25:0] resp;
        int          delay;
    } rr_txn_t;

    rr_txn_t     resp_q[$];
    logic [25:0] out_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    int          plug_map[26];
    int          n_pairs;
    int          m_l, m_m, m_r;
    logic [2:0]  m_wheel;
    logic [25:0] last_out = '0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] lv(input int i);
        return 26'd1 << i;
    endfunction

    function automatic int li(input logic [25:0] v);
        int r = 0;
        for (int i = 0; i < 26; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 26; i++) plug_map[i] = i;
        n_pairs = 0;
        m_l = 0; m_m = 0; m_r = 0;
        m_wheel = '0;
    endfunction

    function automatic void model_step();
        bit ms, ls;
        ms  = (m_r == N0) || (m_m == N1);
        ls  = (m_m == N1);
        m_r = (m_r + 1) % 26;
        if (ms) m_m = (m_m + 1) % 26;
        if (ls) m_l = (m_l + 1) % 26;
    endfunction

    function automatic logic [14:0] m_pos();
        return {5'(m_l), 5'(m_m), 5'(m_r)};
    endfunction

    task automatic check_reset_outputs();
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_pair_count", bus.pair_count, 0);
        check("rst_key_ready", bus.key_ready, 0);
        check("rst_rr_valid", bus.rr_valid, 0);
        check("rst_rr_in", bus.rr_in, 0);
        check("rst_rr_pos", bus.rr_pos, 0);
        check("rst_rr_wheel", bus.rr_wheel, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_letter", bus.out_letter, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    task automatic apply_reset();
        resetn           = 1'b0;
        bus.cfg_clear    = 1'b0;
        bus.pair_wr      = 1'b0;
        bus.pos_load     = 1'b0;
        bus.key_valid    = 1'b0;
        resp_q.delete();
        out_q.delete();
        last_out = '0;
        wait_cnt = 0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("ready_after_release", bus.key_ready, 0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && bus.busy; c++) @(negedge clock);
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 100 && !bus.key_ready; c++) @(negedge clock);
        check("key_ready_timeout", bus.key_ready, 1);
    endtask

    task automatic do_clear();
        bit busy_now;
        busy_now      = bus.busy;
        bus.cfg_clear = 1'b1;
        #1;
        check("clear_blocks_ready", bus.key_ready, 0);
        @(negedge clock);
        bus.cfg_clear = 1'b0;
        if (!busy_now) begin
            for (int i = 0; i < 26; i++) plug_map[i] = i;
            n_pairs = 0;
        end
        check("clear_err", bus.cfg_err, busy_now);
        check("clear_count", bus.pair_count, n_pairs);
    endtask

    task automatic do_pair(input logic [25:0] a, input logic [25:0] b);
        bit ok;
        ok = !bus.busy && (n_pairs < 10) && $onehot(a) && $onehot(b) && (a != b) &&
             (plug_map[li(a)] == li(a)) && (plug_map[li(b)] == li(b));
        bus.pair_a  = a;
        bus.pair_b  = b;
        bus.pair_wr = 1'b1;
        @(negedge clock);
        bus.pair_wr = 1'b0;
        if (ok) begin
            plug_map[li(a)] = li(b);
            plug_map[li(b)] = li(a);
            n_pairs++;
        end
        check("pair_err", bus.cfg_err, !ok);
        check("pair_count", bus.pair_count, n_pairs);
    endtask

    task automatic do_load(input int l, input int m, input int r, input logic [2:0] w);
        bit ok;
        ok = !bus.busy && (l <= 25) && (m <= 25) && (r <= 25);
        bus.pos_init     = {5'(l), 5'(m), 5'(r)};
        bus.wheel_config = w;
        bus.pos_load     = 1'b1;
        @(negedge clock);
        bus.pos_load = 1'b0;
        if (ok) begin
            m_l = l; m_m = m; m_r = r;
            m_wheel = w;
        end
        check("load_err", bus.cfg_err, !ok);
        check("load_pos", bus.rr_pos, m_pos());
        check("load_wheel", bus.rr_wheel, m_wheel);
    endtask

    // Offer one key; for a legal key, queue the predicted rotor request and ciphertext
    task automatic send_key(input logic [25:0] k, input int resp_idx, input int delay,
                            input bit wait_done);
        bit      onehot;
        rr_txn_t t;
        int      n;
        wait_ready();
        onehot = $onehot(k);
        if (onehot) begin
            model_step();
            t.rin   = lv(plug_map[li(k)]);
            t.pos   = m_pos();
            t.wheel = m_wheel;
            t.resp  = lv(resp_idx);
            t.delay = delay;
            resp_q.push_back(t);
            out_q.push_back(lv(plug_map[resp_idx]));
        end
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.key_in    = 26'($urandom);
        check("key_err", bus.cfg_err, !onehot);
        if (!onehot) begin
            check("bad_key_busy", bus.busy, 0);
            return;
        end
        if (wait_done) begin
            n = 0;
            for (int c = 0; c < 200 && bus.busy; c++) begin
                n++;
                @(negedge clock);
            end
            check("letter_latency", n, delay + 3);
            check("letter_done_idle", bus.busy, 0);
        end
    endtask

    // Rotor/reflector unit emulator: checks each request cycle, answers after the queued delay
    initial begin : responder
        bus.rr_done = 1'b0;
        bus.rr_out  = '0;
        forever begin
            @(negedge clock);
            if (bus.rr_valid) begin
                if (resp_q.size() == 0) begin
                    check("rr_valid_unexpected", bus.rr_valid, 0);
                    bus.rr_done = 1'b1;
                end else begin
                    check("rr_in", bus.rr_in, resp_q[0].rin);
                    check("rr_pos", bus.rr_pos, resp_q[0].pos);
                    check("rr_wheel", bus.rr_wheel, resp_q[0].wheel);
                    if (wait_cnt == resp_q[0].delay) begin
                        bus.rr_done = 1'b1;
                        bus.rr_out  = resp_q[0].resp;
                        void'(resp_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        bus.rr_done = 1'b0;
                        bus.rr_out  = 26'($urandom);
                        wait_cnt++;
                    end
                end
            end else begin
                bus.rr_done = 1'($urandom_range(0, 1));
                bus.rr_out  = lv($urandom_range(0, 25));
            end
        end
    end

    // Ciphertext monitor: pops one expectation per out_valid, checks hold otherwise
    initial begin : monitor
        logic [25:0] e;
        forever begin
            @(negedge clock);
            if (bus.out_valid) begin
                if (out_q.size() == 0) begin
                    check("out_valid_unexpected", bus.out_valid, 0);
                end else begin
                    e = out_q.pop_front();
                    check("out_letter", bus.out_letter, e);
                    last_out = e;
                end
            end else begin
                check("out_hold", bus.out_letter, last_out);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int perm[26];
        int j, tmp, sel;
        bus.cfg_clear    = 1'b0;
        bus.pair_wr      = 1'b0;
        bus.pair_a       = '0;
        bus.pair_b       = '0;
        bus.pos_load     = 1'b0;
        bus.pos_init     = '0;
        bus.wheel_config = '0;
        bus.key_valid    = 1'b0;
        bus.key_in       = '0;
        model_reset();
        #1;
        apply_reset();

        // Empty table, positions zero
        send_key(lv(0), $urandom_range(0, 25), 0, 1);

        // Plugboard A-Z and Q-B, then rejected pairs
        do_pair(lv(0), lv(25));
        do_pair(lv(16), lv(1));
        send_key(lv(0), 1, 0, 1);
        do_pair(lv(25), lv(2));
        do_pair(lv(3), lv(3));
        do_pair(lv(3) | lv(4), lv(5));
        do_pair(26'd0, lv(5));

        // Double step, right-notch step, both notches
        do_load(0, 4, 5, 3'd2);
        send_key(lv(7), $urandom_range(0, 25), 0, 1);
        send_key(lv(8), $urandom_range(0, 25), 1, 1);
        do_load(0, 0, 16, 3'd5);
        send_key(lv(9), $urandom_range(0, 25), 0, 1);
        do_load(3, 4, 16, 3'd1);
        send_key(lv(10), $urandom_range(0, 25), 2, 1);

        // Wrap and out-of-range loads
        do_load(25, 25, 25, 3'd7);
        send_key(lv(11), $urandom_range(0, 25), 0, 1);
        do_load(26, 0, 0, 3'd1);
        do_load(0, 30, 0, 3'd2);
        do_load(0, 0, 31, 3'd3);
        send_key(lv(12), $urandom_range(0, 25), 0, 1);

        // Config commands while a letter is in flight are rejected
        send_key(lv(5), $urandom_range(0, 25), 4, 0);
        @(negedge clock);
        do_pair(lv(10), lv(11));
        do_clear();
        wait_idle();

        // Fill the table, then overflow
        do_clear();
        for (int i = 0; i < 26; i++) perm[i] = i;
        for (int i = 25; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 11; i++) do_pair(lv(perm[2 * i]), lv(perm[2 * i + 1]));
        send_key(lv(perm[0]), perm[3], 1, 1);

        // Same-cycle clear and key: key refused, table emptied
        bus.cfg_clear = 1'b1;
        bus.key_in    = lv(3);
        bus.key_valid = 1'b1;
        #1;
        check("clear_key_ready", bus.key_ready, 0);
        @(negedge clock);
        bus.cfg_clear = 1'b0;
        bus.key_valid = 1'b0;
        for (int i = 0; i < 26; i++) plug_map[i] = i;
        n_pairs = 0;
        check("clear_key_count", bus.pair_count, n_pairs);
        check("clear_key_busy", bus.busy, 0);
        check("clear_key_err", bus.cfg_err, 0);

        // Randomized traffic mixing keys, pairs and loads
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)
                do_load($urandom_range(0, 27), $urandom_range(0, 27), $urandom_range(14, 27),
                        3'($urandom_range(0, 7)));
            else if (sel == 1)
                do_pair(lv($urandom_range(0, 25)), lv($urandom_range(0, 25)));
            else
                send_key(lv($urandom_range(0, 25)), $urandom_range(0, 25),
                         $urandom_range(0, 3), 1);
        end

        // Long rotor-unit wait: request must hold for six cycles
        send_key(lv(12), $urandom_range(0, 25), 5, 1);

        // Non-one-hot keys are consumed with an error and no request
        send_key(26'd0, 0, 0, 1);
        send_key(lv(1) | lv(2), 0, 0, 1);
        repeat (3) @(negedge clock);

        // Reset while waiting on the rotor unit
        send_key(lv(9), 3, 20, 0);
        for (int c = 0; c < 20 && !bus.rr_valid; c++) @(negedge clock);
        check("issue_reached", bus.rr_valid, 1);
        @(negedge clock);
        #2;
        apply_reset();
        send_key(lv(0), $urandom_range(0, 25), 1, 1);

        repeat (3) @(negedge clock);
        check("resp_q_drained", resp_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
